riscv_pipeline_top: RTL and testbench

RISCV_PIPELINE_TOP -- requirements
Module: riscv_pipeline_top

---
 rtl/riscv_pipeline_top.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_riscv_pipeline_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipeline_top.sv
// Five-stage RV32I-subset pipeline: top with instruction ROM and data RAM,
// plus the core (forwarding, load-use stall, EX-resolved branches).
module riscv_pipeline_top #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_ADDR_WIDTH      = 10,
  parameter int P_REG_ADDR_WIDTH  = 5,
  parameter int P_IMEM_ADDR_WIDTH = 9,
  parameter int P_DMEM_ADDR_WIDTH = 8
) (
  input logic i_clk,
  input logic i_rst
);
  logic [P_IMEM_ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]                  imem_rdata;
  logic [P_DMEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [P_DATA_WIDTH-1:0]      dmem_wdata;
  logic [P_DATA_WIDTH-1:0]      dmem_rdata;
  logic                         dmem_we;
  logic                         unused_addr_bits;

  logic [P_DATA_WIDTH-1:0] dmem_q [0:2**(P_DMEM_ADDR_WIDTH-2)-1];

  riscv_core #(
    .P_DATA_WIDTH      (P_DATA_WIDTH),
    .P_ADDR_WIDTH      (P_ADDR_WIDTH),
    .P_REG_ADDR_WIDTH  (P_REG_ADDR_WIDTH),
    .P_DMEM_ADDR_WIDTH (P_DMEM_ADDR_WIDTH)
  ) u_riscv_core (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_we_o    (dmem_we),
    .dmem_rdata_i (dmem_rdata)
  );

  instrucmem #(.P_IMEM_ADDR_WIDTH(P_IMEM_ADDR_WIDTH)) u_instrucmem (
    .addr_i  (imem_addr),
    .rdata_o (imem_rdata)
  );

  // Word-addressed RAM; byte offset bits are ignored.
  assign dmem_rdata       = dmem_q[dmem_addr[P_DMEM_ADDR_WIDTH-1:2]];
  assign unused_addr_bits = ^dmem_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (dmem_we) dmem_q[dmem_addr[P_DMEM_ADDR_WIDTH-1:2]] <= dmem_wdata;
  end
endmodule

module instrucmem #(
  parameter int P_IMEM_ADDR_WIDTH = 9
) (
  input  logic [P_IMEM_ADDR_WIDTH-1:0] addr_i,
  output logic [31:0]                  rdata_o
);
  // Unloaded words decode as addi x0,x0,0.
  logic [31:0] l_rom [0:2**P_IMEM_ADDR_WIDTH-1] = '{default: 32'h0000_0013};

  assign rdata_o = l_rom[addr_i];
endmodule

module riscv_core #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_ADDR_WIDTH      = 10,
  parameter int P_REG_ADDR_WIDTH  = 5,
  parameter int P_DMEM_ADDR_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic [P_ADDR_WIDTH-2:0]      imem_addr_o,
  input  logic [31:0]                  imem_rdata_i,
  output logic [P_DMEM_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [P_DATA_WIDTH-1:0]      dmem_wdata_o,
  output logic                         dmem_we_o,
  input  logic [P_DATA_WIDTH-1:0]      dmem_rdata_i
);
  localparam int DW = P_DATA_WIDTH;
  localparam int RW = P_REG_ADDR_WIDTH;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jal;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] if_id_pc;
  logic [31:0]   if_id_instr;
  logic [DW-1:0] rf_q [0:2**RW-1];

  logic [DW-1:0] id_ex_pc_q, id_ex_a_q, id_ex_b_q, id_ex_imm_q;
  logic [RW-1:0] id_ex_rs1_q, id_ex_rs2_q, id_ex_rd_q;
  ctrl_t         id_ex_ctrl_q;

  logic [DW-1:0] ex_mem_result_q, ex_mem_wdata_q;
  logic [RW-1:0] ex_mem_rd_q;
  logic          ex_mem_reg_write_q, ex_mem_mem_read_q, ex_mem_mem_write_q;

  logic [DW-1:0] mem_wb_data_q;
  logic [RW-1:0] mem_wb_rd_q;
  logic          mem_wb_reg_write_q;

  // ID
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rs1_id, rs2_id, rd_id;
  logic [DW-1:0] imm_i, imm_s, imm_b, imm_j, imm_id, rs1_val, rs2_val;
  ctrl_t         dec;
  logic          stall;

  assign opcode = if_id_instr[6:0];
  assign funct3 = if_id_instr[14:12];
  assign funct7 = if_id_instr[31:25];
  assign rd_id  = if_id_instr[7 +: RW];
  assign rs1_id = if_id_instr[15 +: RW];
  assign rs2_id = if_id_instr[20 +: RW];
  assign imm_i  = {{(DW-12){if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s  = {{(DW-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b  = {{(DW-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                   if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign imm_j  = {{(DW-21){if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                   if_id_instr[20], if_id_instr[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    imm_id = '0;
    case (opcode)
      7'h33: begin
        dec.reg_write = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec.alu_op = ALU_ADD;
          10'b0100000_000: dec.alu_op = ALU_SUB;
          10'b0000000_111: dec.alu_op = ALU_AND;
          10'b0000000_110: dec.alu_op = ALU_OR;
          10'b0000000_010: dec.alu_op = ALU_SLT;
          default:         dec.reg_write = 1'b0;
        endcase
      end
      7'h13: begin
        imm_id        = imm_i;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000:  dec.alu_op = ALU_ADD;
          3'b111:  dec.alu_op = ALU_AND;
          3'b110:  dec.alu_op = ALU_OR;
          3'b010:  dec.alu_op = ALU_SLT;
          default: dec.reg_write = 1'b0;
        endcase
      end
      7'h03: begin
        imm_id = imm_i;
        if (funct3 == 3'b010) begin
          dec.reg_write = 1'b1;
          dec.mem_read  = 1'b1;
          dec.alu_src   = 1'b1;
        end
      end
      7'h23: begin
        imm_id = imm_s;
        if (funct3 == 3'b010) begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
        end
      end
      7'h63: begin
        imm_id     = imm_b;
        dec.branch = (funct3 == 3'b000);
      end
      7'h6f: begin
        imm_id        = imm_j;
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Write-through so the WB result is seen by the ID read in the same cycle.
  always_comb begin
    rs1_val = rf_q[rs1_id];
    rs2_val = rf_q[rs2_id];
    if (mem_wb_reg_write_q && mem_wb_rd_q == rs1_id) rs1_val = mem_wb_data_q;
    if (mem_wb_reg_write_q && mem_wb_rd_q == rs2_id) rs2_val = mem_wb_data_q;
    if (rs1_id == '0) rs1_val = '0;
    if (rs2_id == '0) rs2_val = '0;
  end

  assign stall = id_ex_ctrl_q.mem_read && (id_ex_rd_q != '0) &&
                 (id_ex_rd_q == rs1_id || id_ex_rd_q == rs2_id);

  // EX
  logic [DW-1:0] ex_a, ex_b, alu_b, alu_res, ex_result, ex_target;
  logic          take;

  always_comb begin
    ex_a = id_ex_a_q;
    ex_b = id_ex_b_q;
    if (mem_wb_reg_write_q && mem_wb_rd_q != '0 && mem_wb_rd_q == id_ex_rs1_q) ex_a = mem_wb_data_q;
    if (mem_wb_reg_write_q && mem_wb_rd_q != '0 && mem_wb_rd_q == id_ex_rs2_q) ex_b = mem_wb_data_q;
    if (ex_mem_reg_write_q && ex_mem_rd_q != '0 && ex_mem_rd_q == id_ex_rs1_q) ex_a = ex_mem_result_q;
    if (ex_mem_reg_write_q && ex_mem_rd_q != '0 && ex_mem_rd_q == id_ex_rs2_q) ex_b = ex_mem_result_q;
  end

  assign alu_b = id_ex_ctrl_q.alu_src ? id_ex_imm_q : ex_b;

  always_comb begin
    case (id_ex_ctrl_q.alu_op)
      ALU_SUB: alu_res = ex_a - alu_b;
      ALU_AND: alu_res = ex_a & alu_b;
      ALU_OR:  alu_res = ex_a | alu_b;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(ex_a) < $signed(alu_b))};
      default: alu_res = ex_a + alu_b;
    endcase
  end

  assign ex_result = id_ex_ctrl_q.jal ? id_ex_pc_q + DW'(4) : alu_res;
  assign ex_target = id_ex_pc_q + id_ex_imm_q;
  assign take      = id_ex_ctrl_q.jal || (id_ex_ctrl_q.branch && ex_a == ex_b);

  // Flush wins over stall.
  assign pc_d = take ? ex_target : (stall ? pc_q : pc_q + DW'(4));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q               <= '0;
      if_id_pc           <= '0;
      if_id_instr        <= NOP;
      id_ex_pc_q         <= '0;
      id_ex_a_q          <= '0;
      id_ex_b_q          <= '0;
      id_ex_imm_q        <= '0;
      id_ex_rs1_q        <= '0;
      id_ex_rs2_q        <= '0;
      id_ex_rd_q         <= '0;
      id_ex_ctrl_q       <= '0;
      ex_mem_result_q    <= '0;
      ex_mem_wdata_q     <= '0;
      ex_mem_rd_q        <= '0;
      ex_mem_reg_write_q <= 1'b0;
      ex_mem_mem_read_q  <= 1'b0;
      ex_mem_mem_write_q <= 1'b0;
      mem_wb_data_q      <= '0;
      mem_wb_rd_q        <= '0;
      mem_wb_reg_write_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (take) begin
        if_id_pc    <= '0;
        if_id_instr <= NOP;
      end else if (!stall) begin
        if_id_pc    <= pc_q;
        if_id_instr <= imem_rdata_i;
      end
      if (take || stall) begin
        id_ex_ctrl_q <= '0;
        id_ex_rd_q   <= '0;
      end else begin
        id_ex_ctrl_q <= dec;
        id_ex_rd_q   <= rd_id;
      end
      id_ex_pc_q         <= if_id_pc;
      id_ex_a_q          <= rs1_val;
      id_ex_b_q          <= rs2_val;
      id_ex_imm_q        <= imm_id;
      id_ex_rs1_q        <= rs1_id;
      id_ex_rs2_q        <= rs2_id;
      ex_mem_result_q    <= ex_result;
      ex_mem_wdata_q     <= ex_b;
      ex_mem_rd_q        <= id_ex_rd_q;
      ex_mem_reg_write_q <= id_ex_ctrl_q.reg_write;
      ex_mem_mem_read_q  <= id_ex_ctrl_q.mem_read;
      ex_mem_mem_write_q <= id_ex_ctrl_q.mem_write;
      mem_wb_data_q      <= ex_mem_mem_read_q ? dmem_rdata_i : ex_mem_result_q;
      mem_wb_rd_q        <= ex_mem_rd_q;
      mem_wb_reg_write_q <= ex_mem_reg_write_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**RW; i++) rf_q[i] <= '0;
    end else if (mem_wb_reg_write_q && mem_wb_rd_q != '0) begin
      rf_q[mem_wb_rd_q] <= mem_wb_data_q;
    end
  end

  assign imem_addr_o  = pc_q[P_ADDR_WIDTH:2];
  assign dmem_addr_o  = ex_mem_result_q[P_DMEM_ADDR_WIDTH-1:0];
  assign dmem_wdata_o = ex_mem_wdata_q;
  assign dmem_we_o    = ex_mem_mem_write_q;
endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Directed programs loaded into the ROM; data-memory writes are logged and
// compared against hand-computed results.
module tb_riscv_pipeline_top;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [6:0]  OP_I = 7'h13;
  localparam logic [6:0]  OP_L = 7'h03;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  riscv_pipeline_top dut (
    .i_clk (clk),
    .i_rst (rst)
  );

  always #2 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && dut.dmem_we) begin
      wa_q.push_back(dut.dmem_addr);
      wd_q.push_back(dut.dmem_wdata);
      wc_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] f_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] f_s(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] f_b(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] f_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) dut.u_instrucmem.l_rom[i] = NOP;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.u_instrucmem.l_rom[idx] = w;
  endtask

  task automatic run(input int n);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_cnt(input string tag, input int n);
    chk({tag, "_count"}, wa_q.size(), n);
  endtask

  task automatic exp_wr(input string tag, input int idx, input logic [31:0] a,
                        input logic [31:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, {24'h0, wa_q[idx]}, a);
      chk({tag, "_data"}, wd_q[idx], d);
    end else begin
      chk({tag, "_present"}, wa_q.size(), idx + 1);
    end
  endtask

  task automatic load_main();
    clear_rom();
    put(0,  f_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I));
    put(1,  f_i(12'd3, 5'd0, 3'd0, 5'd2, OP_I));
    put(2,  f_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    put(3,  f_r(7'h20, 5'd2, 5'd3, 3'd0, 5'd4));
    put(4,  f_b(13'd8, 5'd1, 5'd4));
    put(5,  f_i(12'd0, 5'd0, 3'd0, 5'd3, OP_I));
    put(6,  f_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5));
    put(7,  f_s(12'd96, 5'd3, 5'd0));
    put(8,  f_i(12'd96, 5'd0, 3'd2, 5'd6, OP_L));
    put(9,  f_r(7'h00, 5'd4, 5'd6, 3'd0, 5'd7));
    put(10, f_j(21'd8, 5'd8));
    put(11, f_i(12'd0, 5'd0, 3'd0, 5'd7, OP_I));
    put(12, f_r(7'h00, 5'd7, 5'd8, 3'd7, 5'd9));
    put(13, f_r(7'h00, 5'd9, 5'd7, 3'd0, 5'd10));
    put(14, f_s(12'd100, 5'd10, 5'd0));
    put(15, f_j(21'd0, 5'd0));
  endtask

  initial begin
    logic [31:0] w0;

    // Reset hold and first fetch
    clear_rom();
    w0 = f_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I);
    put(0, w0);
    put(1, f_j(21'd0, 5'd0));
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_if_id_pc", dut.u_riscv_core.if_id_pc, 32'h0);
      chk("rst_if_id_instr", dut.u_riscv_core.if_id_instr, NOP);
      chk("rst_dmem_we", {31'h0, dut.dmem_we}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch_pc", dut.u_riscv_core.if_id_pc, 32'h0);
    chk("first_fetch_instr", dut.u_riscv_core.if_id_instr, w0);
    @(negedge clk);
    chk("second_fetch_pc", dut.u_riscv_core.if_id_pc, 32'h4);

    // Back-to-back forwarding
    clear_rom();
    put(0, f_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I));
    put(1, f_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
    put(2, f_s(12'd100, 5'd2, 5'd0));
    put(3, f_j(21'd0, 5'd0));
    run(20);
    exp_cnt("fwd", 1);
    exp_wr("fwd", 0, 32'd100, 32'd10);

    // Load-use stall
    clear_rom();
    put(0, f_i(12'd7, 5'd0, 3'd0, 5'd1, OP_I));
    put(1, f_s(12'd0, 5'd1, 5'd0));
    put(2, f_i(12'd0, 5'd0, 3'd2, 5'd2, OP_L));
    put(3, f_r(7'h00, 5'd2, 5'd2, 3'd0, 5'd3));
    put(4, f_s(12'd100, 5'd3, 5'd0));
    put(5, f_j(21'd0, 5'd0));
    run(25);
    exp_cnt("ldu", 2);
    exp_wr("ldu_st0", 0, 32'd0, 32'd7);
    exp_wr("ldu_st1", 1, 32'd100, 32'd14);
    if (wc_q.size() >= 2) chk("ldu_stall_gap", wc_q[1] - wc_q[0], 32'd4);
    else chk("ldu_stall_gap_present", wc_q.size(), 32'd2);

    // Taken branch flushes the two following stores
    clear_rom();
    put(0, f_b(13'd12, 5'd0, 5'd0));
    put(1, f_s(12'd100, 5'd0, 5'd0));
    put(2, f_s(12'd100, 5'd0, 5'd0));
    put(3, f_i(12'd33, 5'd0, 3'd0, 5'd5, OP_I));
    put(4, f_s(12'd104, 5'd5, 5'd0));
    put(5, f_j(21'd0, 5'd0));
    run(25);
    exp_cnt("beq", 1);
    exp_wr("beq_target", 0, 32'd104, 32'd33);

    // x0 stays zero and is never forwarded
    clear_rom();
    put(0, f_i(12'd9, 5'd0, 3'd0, 5'd0, OP_I));
    put(1, f_s(12'd100, 5'd0, 5'd0));
    put(2, f_j(21'd0, 5'd0));
    run(20);
    exp_cnt("x0", 1);
    exp_wr("x0", 0, 32'd100, 32'd0);

    // ALU ops: signed slt/slti, ori, andi, or, sub
    clear_rom();
    put(0,  f_i(12'hFFD, 5'd0, 3'd0, 5'd1, OP_I));
    put(1,  f_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd2));
    put(2,  f_i(12'hFFC, 5'd1, 3'd2, 5'd3, OP_I));
    put(3,  f_i(12'd6, 5'd2, 3'd6, 5'd4, OP_I));
    put(4,  f_i(12'h0F0, 5'd1, 3'd7, 5'd5, OP_I));
    put(5,  f_r(7'h00, 5'd5, 5'd4, 3'd6, 5'd6));
    put(6,  f_r(7'h00, 5'd3, 5'd6, 3'd0, 5'd6));
    put(7,  f_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd7));
    put(8,  f_s(12'd100, 5'd6, 5'd0));
    put(9,  f_s(12'd104, 5'd7, 5'd0));
    put(10, f_j(21'd0, 5'd0));
    run(30);
    exp_cnt("alu", 2);
    exp_wr("alu_mix", 0, 32'd100, 32'h0000_00F7);
    exp_wr("alu_sub", 1, 32'd104, 32'd3);

    // Full program: branch, store/load, load-use, jal link
    load_main();
    run(60);
    exp_cnt("main", 2);
    exp_wr("main_mid", 0, 32'd96, 32'd8);
    exp_wr("main_final", 1, 32'd100, 32'd25);

    // Reset in the middle of execution, then rerun from address 0
    load_main();
    run(9);
    rst = 1'b1;
    #1;
    chk("midrst_pc", dut.u_riscv_core.if_id_pc, 32'h0);
    chk("midrst_instr", dut.u_riscv_core.if_id_instr, NOP);
    chk("midrst_we", {31'h0, dut.dmem_we}, 32'h0);
    run(60);
    exp_cnt("rerun", 2);
    exp_wr("rerun_final", 1, 32'd100, 32'd25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
